bus_switch_scheduler: RTL and testbench

- Arbitrates route requests from R independent requesters and issues route commands to the N-endpoint bus switch (`busSwitch`) over its cmd handshake.
- Tracks endpoint occupancy so that no issued route overlaps an endpoint still in a transfer.
- Round-robin fairness among eligible requesters; requests violating the allowed-route mask are dropped with an error pulse.
- Sits between the protocol sequencers (requesters) and the switch's cmd/cmd_isReady/cmd_canReceive port.

---
 rtl/bus_switch_scheduler_if.sv | 25 ++
 rtl/bus_switch_scheduler.sv | 173 +++++++++++++++++
 tb/tb_bus_switch_scheduler.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_switch_scheduler_if.sv
// Request-side and switch-side handshakes of bus_switch_scheduler.
// Handshake rule for both channels: a transfer happens in exactly the cycles
// where *_isReady && *_canReceive; the *_isReady side holds its data stable
// until then. On the request side *_canReceive is a one-hot grant per requester.
interface bus_switch_scheduler_if #(
    parameter int N = 4,
    parameter int R = 3
);
    logic [R*2*N-1:0] req_cmd;
    logic [R-1:0]     req_isReady;
    logic [R-1:0]     req_canReceive;
    logic [2*N-1:0]   cmd;
    logic             cmd_isReady;
    logic             cmd_canReceive;

    modport master (
        input  req_cmd, req_isReady, cmd_canReceive,
        output req_canReceive, cmd, cmd_isReady
    );

    modport slave (
        output req_cmd, req_isReady, cmd_canReceive,
        input  req_canReceive, cmd, cmd_isReady
    );
endinterface

// File: rtl/bus_switch_scheduler.sv
// Round-robin route scheduler feeding the busSwitch cmd port with endpoint occupancy tracking.
// Defining BUS_SWITCH_SCHEDULER_STATS_EN adds the issue_count and stall_count counters.
module bus_switch_scheduler #(
    parameter int N = 4,
    parameter int R = 3,
    localparam int RW = (R > 1) ? $clog2(R) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    bus_switch_scheduler_if.master bus,
    input  logic [N*N-1:0]         allowedCMDMask,
    input  logic [N-1:0]           src_done,
    output logic [N-1:0]           busy,
    output logic                   err_drop,
    output logic [RW-1:0]          rrPtr
`ifdef BUS_SWITCH_SCHEDULER_STATS_EN
    ,
    output logic [31:0]            issue_count,
    output logic [31:0]            stall_count
`endif
);
    localparam int CW = 2 * N;
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [CW-1:0]       cmdReg;
    logic                cmdValid;
    logic [N-1:0]        busyReg;
    logic [N-1:0][N-1:0] routeMap;
    logic [RW-1:0]       rrReg;
    logic                errReg;

    logic [R-1:0][N-1:0] reqSrc;
    logic [R-1:0][N-1:0] reqDst;
    logic [R-1:0]        reqBad;
    logic [R-1:0]        reqEligible;

    // Bad requests are always eligible so they get consumed and reported, even while endpoints are busy.
    always_comb begin
        logic [N-1:0] allowedCol;
        allowedCol = '0;
        reqSrc = '0;
        reqDst = '0;
        reqBad = '0;
        reqEligible = '0;
        for (int r = 0; r < R; r++) begin
            reqSrc[r] = bus.req_cmd[r*CW +: N];
            reqDst[r] = bus.req_cmd[r*CW+N +: N];
            allowedCol = '0;
            for (int t = 0; t < N; t++) begin
                for (int f = 0; f < N; f++) begin
                    allowedCol[t] = allowedCol[t] | (reqSrc[r][f] & allowedCMDMask[t*N+f]);
                end
            end
            reqBad[r] = (reqSrc[r] == '0) || ((reqSrc[r] & (reqSrc[r] - ONE)) != '0) ||
                        (reqDst[r] == '0) || ((reqDst[r] & ~allowedCol) != '0);
            reqEligible[r] = bus.req_isReady[r] &&
                             (reqBad[r] || (((reqSrc[r] | reqDst[r]) & busyReg) == '0));
        end
    end

    logic          canArb;
    logic          grantValid;
    logic [RW-1:0] winner;
    logic [R-1:0]  grant;
    logic [N-1:0]  winSrc;
    logic [N-1:0]  winDst;
    logic          winBad;

    always_comb begin
        int idx;
        idx = 0;
        grantValid = 1'b0;
        winner = '0;
        canArb = !cmdValid || bus.cmd_canReceive;
        for (int k = 0; k < R; k++) begin
            idx = int'(rrReg) + k;
            if (idx >= R) idx = idx - R;
            if (canArb && !grantValid && reqEligible[idx]) begin
                grantValid = 1'b1;
                winner = RW'(idx);
            end
        end
        grant = '0;
        winSrc = '0;
        winDst = '0;
        winBad = 1'b0;
        for (int r = 0; r < R; r++) begin
            if (grantValid && (winner == RW'(r))) begin
                grant[r] = 1'b1;
                winSrc = reqSrc[r];
                winDst = reqDst[r];
                winBad = reqBad[r];
            end
        end
    end

    logic [N-1:0]        setMask;
    logic [N-1:0]        clrMask;
    logic [N-1:0]        busyNext;
    logic [N-1:0][N-1:0] mapNext;

    // Completions are applied first so that a new route's set bits win over a clear.
    always_comb begin
        clrMask = '0;
        setMask = '0;
        mapNext = routeMap;
        for (int s = 0; s < N; s++) begin
            if (src_done[s] && busyReg[s]) begin
                clrMask = clrMask | routeMap[s];
                clrMask[s] = 1'b1;
                mapNext[s] = '0;
            end
        end
        if (grantValid && !winBad) begin
            setMask = winSrc | winDst;
            for (int s = 0; s < N; s++) begin
                if (winSrc[s]) mapNext[s] = winDst;
            end
        end
        busyNext = (busyReg & ~clrMask) | setMask;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmdReg   <= '0;
            cmdValid <= 1'b0;
            busyReg  <= '0;
            routeMap <= '0;
            rrReg    <= '0;
            errReg   <= 1'b0;
        end else begin
            busyReg  <= busyNext;
            routeMap <= mapNext;
            errReg   <= grantValid && winBad;
            if (grantValid) begin
                rrReg <= (int'(winner) == R - 1) ? '0 : RW'(int'(winner) + 1);
            end
            if (grantValid && !winBad) begin
                cmdReg   <= {winDst, winSrc};
                cmdValid <= 1'b1;
            end else if (cmdValid && bus.cmd_canReceive) begin
                cmdValid <= 1'b0;
            end
        end
    end

    busySetClearOverlap: assert property (@(posedge clk) disable iff (rst) (setMask & clrMask) == '0);

`ifdef BUS_SWITCH_SCHEDULER_STATS_EN
    logic [31:0] issueCnt;
    logic [31:0] stallCnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            issueCnt <= '0;
            stallCnt <= '0;
        end else begin
            if (cmdValid && bus.cmd_canReceive) issueCnt <= issueCnt + 32'd1;
            if ((|bus.req_isReady) && !grantValid) stallCnt <= stallCnt + 32'd1;
        end
    end

    assign issue_count = issueCnt;
    assign stall_count = stallCnt;
`endif

    assign bus.req_canReceive = grant;
    assign bus.cmd            = cmdReg;
    assign bus.cmd_isReady    = cmdValid;
    assign busy               = busyReg;
    assign err_drop           = errReg;
    assign rrPtr              = rrReg;
endmodule

// File: tb/tb_bus_switch_scheduler.sv
// Directed bench for bus_switch_scheduler (N=6, R=3) with an endpoint-ownership model
// checked every cycle plus hand-computed literal expectations.
module tb_bus_switch_scheduler;
    localparam int N  = 6;
    localparam int R  = 3;
    localparam int CW = 2 * N;

    logic           clk;
    logic           rst;
    logic [N*N-1:0] allowed;
    logic [N-1:0]   srcDone;
    logic [N-1:0]   busy;
    logic           err_drop;
    logic [1:0]     rrPtr;
`ifdef BUS_SWITCH_SCHEDULER_STATS_EN
    logic [31:0]    issue_count;
    logic [31:0]    stall_count;
`endif

    bus_switch_scheduler_if #(.N(N), .R(R)) bus ();

    bus_switch_scheduler #(.N(N), .R(R)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .allowedCMDMask (allowed),
        .src_done       (srcDone),
        .busy           (busy),
        .err_drop       (err_drop),
        .rrPtr          (rrPtr)
`ifdef BUS_SWITCH_SCHEDULER_STATS_EN
        ,
        .issue_count    (issue_count),
        .stall_count    (stall_count)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic setReq(input int r, input logic [CW-1:0] c);
        bus.req_cmd[r*CW +: CW] = c;
    endtask

    function automatic logic [CW-1:0] route(input int s, input logic [N-1:0] d);
        logic [N-1:0] one;
        one = 1;
        return {d, one << s};
    endfunction

    // scoreboard: cmd register as a queue, endpoint ownership by source index
    logic [CW-1:0] exp_q[$];
    int            owner [N];
    int            mRr;
    bit            mErr;
    bit            modelLive = 0;
    int unsigned   mIssue;
    int unsigned   mStall;
    logic [N-1:0]  mBusyV;
    logic [N-1:0]  mSrc [R];
    logic [N-1:0]  mDst [R];
    int            mFrom [R];
    bit            mBad [R];
    bit            mElig [R];
    int            mWin;
    logic [R-1:0]  mGrant;

    always @(negedge clk) begin
        mBusyV = '0;
        for (int e = 0; e < N; e++) if (owner[e] >= 0) mBusyV[e] = 1'b1;
        for (int r = 0; r < R; r++) begin
            mSrc[r] = bus.req_cmd[r*CW +: N];
            mDst[r] = bus.req_cmd[r*CW+N +: N];
            mFrom[r] = 0;
            for (int e = 0; e < N; e++) if (mSrc[r][e]) mFrom[r] = e;
            mBad[r] = ($countones(mSrc[r]) != 1) || (mDst[r] == '0);
            if (!mBad[r]) begin
                for (int t = 0; t < N; t++) begin
                    if (mDst[r][t] && !allowed[t*N+mFrom[r]]) mBad[r] = 1'b1;
                end
            end
            mElig[r] = bus.req_isReady[r] && (mBad[r] || (((mSrc[r] | mDst[r]) & mBusyV) == '0));
        end
        mWin = -1;
        if (exp_q.size() == 0 || bus.cmd_canReceive) begin
            for (int k = 0; k < R; k++) begin
                if (mWin < 0 && mElig[(mRr + k) % R]) mWin = (mRr + k) % R;
            end
        end
        mGrant = '0;
        if (mWin >= 0) mGrant[mWin] = 1'b1;

        if (modelLive && !rst) begin
            chk("m_grant", bus.req_canReceive, mGrant);
            chk("m_cmd_valid", bus.cmd_isReady, exp_q.size() != 0);
            if (exp_q.size() != 0) chk("m_cmd", bus.cmd, exp_q[0]);
            chk("m_busy", busy, mBusyV);
            chk("m_err_drop", err_drop, mErr);
            chk("m_rr", rrPtr, mRr);
`ifdef BUS_SWITCH_SCHEDULER_STATS_EN
            chk("m_issue_count", issue_count, mIssue);
            chk("m_stall_count", stall_count, mStall);
`endif
        end

        if (rst) begin
            exp_q.delete();
            for (int e = 0; e < N; e++) owner[e] = -1;
            mRr = 0;
            mErr = 0;
            mIssue = 0;
            mStall = 0;
            modelLive = 1;
        end else if (modelLive) begin
            if (exp_q.size() != 0 && bus.cmd_canReceive) begin
                void'(exp_q.pop_front());
                mIssue++;
            end
            if ((|bus.req_isReady) && mWin < 0) mStall++;
            for (int s = 0; s < N; s++) begin
                if (srcDone[s] && mBusyV[s]) begin
                    for (int e = 0; e < N; e++) if (e == s || owner[e] == s) owner[e] = -1;
                end
            end
            mErr = 0;
            if (mWin >= 0) begin
                mRr = (mWin + 1) % R;
                if (mBad[mWin]) begin
                    mErr = 1;
                end else begin
                    exp_q.push_back({mDst[mWin], mSrc[mWin]});
                    for (int e = 0; e < N; e++) begin
                        if (mSrc[mWin][e] || mDst[mWin][e]) owner[e] = mFrom[mWin];
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout at %0t", $time);
        $fatal(1, "bench did not finish");
    end

    initial begin
        rst = 1'b1;
        allowed = '1;
        srcDone = '0;
        bus.req_cmd = '0;
        bus.req_isReady = '0;
        bus.cmd_canReceive = 1'b1;
        tick();
        tick();
        look();
        chk("reset_cmd", bus.cmd, 12'h000);
        chk("reset_cmd_valid", bus.cmd_isReady, 1'b0);
        chk("reset_busy", busy, 6'b000000);
        chk("reset_err", err_drop, 1'b0);
        chk("reset_grant", bus.req_canReceive, 3'b000);
        chk("reset_rr", rrPtr, 2'd0);
        tick();
        rst = 1'b0;

        // single route 0->2
        tick();
        setReq(0, route(0, 6'b000100));
        bus.req_isReady = 3'b001;
        look();
        chk("single_grant", bus.req_canReceive, 3'b001);
        tick();
        bus.req_isReady = 3'b000;
        look();
        chk("single_cmd_valid", bus.cmd_isReady, 1'b1);
        chk("single_cmd", bus.cmd, 12'h101);
        chk("single_busy", busy, 6'b000101);
        repeat (4) tick();
        tick();
        srcDone = 6'b000001;
        look();
        chk("single_busy_hold", busy, 6'b000101);
        chk("single_cmd_idle", bus.cmd_isReady, 1'b0);
        tick();
        srcDone = '0;
        look();
        chk("single_busy_clear", busy, 6'b000000);

        // conflict on endpoint 2
        tick();
        setReq(0, route(0, 6'b000100));
        bus.req_isReady = 3'b001;
        look();
        chk("conflict_grant0", bus.req_canReceive, 3'b001);
        tick();
        setReq(1, route(1, 6'b000100));
        bus.req_isReady = 3'b010;
        look();
        chk("conflict_block", bus.req_canReceive, 3'b000);
        for (int i = 0; i < 3; i++) begin
            tick();
            look();
            chk("conflict_wait", bus.req_canReceive, 3'b000);
        end
        tick();
        srcDone = 6'b000001;
        look();
        chk("conflict_wait_done", bus.req_canReceive, 3'b000);
        tick();
        srcDone = '0;
        look();
        chk("conflict_busy_free", busy, 6'b000000);
        chk("conflict_regrant", bus.req_canReceive, 3'b010);
        tick();
        bus.req_isReady = 3'b000;
        look();
        chk("conflict_cmd", bus.cmd, 12'h102);
        chk("conflict_busy", busy, 6'b000110);
        tick();
        srcDone = 6'b000010;
        tick();
        srcDone = '0;
        look();
        chk("conflict_clear", busy, 6'b000000);

        // reset while a route is held under backpressure
        tick();
        setReq(0, route(0, 6'b000100));
        bus.req_isReady = 3'b001;
        bus.cmd_canReceive = 1'b0;
        look();
        chk("midrst_grant", bus.req_canReceive, 3'b001);
        tick();
        bus.req_isReady = 3'b000;
        look();
        chk("midrst_busy_pre", busy, 6'b000101);
        chk("midrst_valid_pre", bus.cmd_isReady, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.cmd_canReceive = 1'b1;
        look();
        chk("midrst_busy", busy, 6'b000000);
        chk("midrst_valid", bus.cmd_isReady, 1'b0);
        chk("midrst_rr", rrPtr, 2'd0);
`ifdef BUS_SWITCH_SCHEDULER_STATS_EN
        chk("midrst_issue", issue_count, 32'd0);
        chk("midrst_stall", stall_count, 32'd0);
`endif

        // round robin over disjoint routes, each completed right away
        tick();
        setReq(0, route(0, 6'b000010));
        setReq(1, route(2, 6'b001000));
        setReq(2, route(4, 6'b100000));
        bus.req_isReady = 3'b111;
        look();
        chk("rr_grant0", bus.req_canReceive, 3'b001);
        tick();
        srcDone = 6'b000001;
        look();
        chk("rr_grant1", bus.req_canReceive, 3'b010);
        tick();
        srcDone = 6'b000100;
        look();
        chk("rr_grant2", bus.req_canReceive, 3'b100);
        tick();
        srcDone = 6'b010000;
        look();
        chk("rr_wrap", rrPtr, 2'd0);
        chk("rr_grant3", bus.req_canReceive, 3'b001);
        tick();
        bus.req_isReady = 3'b000;
        srcDone = 6'b000001;
        tick();
        srcDone = '0;
        look();
        chk("rr_idle", busy, 6'b000000);

        // backpressure for 4 cycles
        tick();
        bus.cmd_canReceive = 1'b0;
        bus.req_isReady = 3'b011;
        look();
        chk("bp_grant", bus.req_canReceive, 3'b010);
        tick();
        bus.req_isReady = 3'b001;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            look();
            chk("bp_hold_valid", bus.cmd_isReady, 1'b1);
            chk("bp_hold_cmd", bus.cmd, 12'h204);
            chk("bp_no_grant", bus.req_canReceive, 3'b000);
        end
        tick();
        bus.cmd_canReceive = 1'b1;
        look();
        chk("bp_refill_grant", bus.req_canReceive, 3'b001);
        tick();
        bus.req_isReady = 3'b000;
        look();
        chk("bp_next_cmd", bus.cmd, 12'h081);
        chk("bp_busy", busy, 6'b001111);
        tick();
        srcDone = 6'b000101;
        look();
        chk("bp_drain", bus.cmd_isReady, 1'b0);
        tick();
        srcDone = '0;
        look();
        chk("bp_clear", busy, 6'b000000);

        // malformed source, disallowed route, empty destination
        tick();
        setReq(2, {6'b000100, 6'b000011});
        bus.req_isReady = 3'b100;
        look();
        chk("err_src_grant", bus.req_canReceive, 3'b100);
        tick();
        bus.req_isReady = 3'b000;
        look();
        chk("err_src_pulse", err_drop, 1'b1);
        chk("err_src_valid", bus.cmd_isReady, 1'b0);
        chk("err_src_busy", busy, 6'b000000);
        tick();
        look();
        chk("err_src_end", err_drop, 1'b0);
        tick();
        allowed[4*N+3] = 1'b0;
        setReq(1, route(3, 6'b010000));
        bus.req_isReady = 3'b010;
        look();
        chk("err_dis_grant", bus.req_canReceive, 3'b010);
        tick();
        bus.req_isReady = 3'b000;
        look();
        chk("err_dis_pulse", err_drop, 1'b1);
        chk("err_dis_valid", bus.cmd_isReady, 1'b0);
        chk("err_dis_busy", busy, 6'b000000);
        tick();
        look();
        chk("err_dis_end", err_drop, 1'b0);
        tick();
        setReq(0, {6'b000000, 6'b000001});
        bus.req_isReady = 3'b001;
        look();
        chk("err_dst0_grant", bus.req_canReceive, 3'b001);
        tick();
        bus.req_isReady = 3'b000;
        allowed = '1;
        look();
        chk("err_dst0_pulse", err_drop, 1'b1);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
